cnn_line_buffer: RTL and testbench
==================================

// Module: cnn_line_buffer
// PURPOSE
//  Parametrised multi-line delay buffer for the CNN conv window stage.
//  Delays the incoming pixel/weight stream by 1..NUM_LINES rows, one row = depth_q accepted words.
//  Supports run-time row length per layer, valid-gated shifting, flush and per-line fill status.
//  Sits between the input feature-map fetch and the KxK window/MAC array.
// PARAMETERS
//  DATA_W     48  width of one stream word
//  MAX_DEPTH  62  maximum row delay, in words; storage per line
//  NUM_LINES  2   cascaded row delays, giving a (NUM_LINES+1)-row window
//  CNT_W      $clog2(NUM_LINES*MAX_DEPTH+1)  fill-counter width (derived, do not override)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  asynchronous, active-low reset
//  flush      in   1                  sync clear of contents/counter; loads depth_cfg
//  depth_cfg  in   $clog2(MAX_DEPTH+1)  row length for the next layer
//  in_valid   in   1                  in_data accepted this cycle
//  in_data    in   DATA_W             stream word
//  line_data  out  NUM_LINES*DATA_W   slice k = word delayed (k+1)*depth_q shifts
//  line_valid out  NUM_LINES          bit k = slice k holds real data
//  cfg_err    out  1                  one-cycle pulse: flush saw out-of-range depth_cfg
// BEHAVIOUR
//  Reset (rst==0, async): all storage 0, fill_cnt 0, depth_q=MAX_DEPTH.
//   line_data 0, line_valid 0, cfg_err 0.
//  Shift: only on in_valid && !flush; all lines shift together; else full hold (stall).
//  Line 0 input = in_data; line k input = line k-1 tap output (cascade).
//  Tap: line k output = stage[depth_q-1] of line k. Combinational from regs, no extra latency.
//   A word accepted on shift n appears on slice 0 after shift n+depth_q-1 completes.
//   It appears on slice k after (k+1)*depth_q accepted shifts in total.
//   Stages >= depth_q still shift; they are never observed.
//  fill_cnt: +1 per accepted shift, saturates at NUM_LINES*depth_q.
//   line_valid[k] = (fill_cnt >= (k+1)*depth_q), from registered count, no combinational path from in_valid.
//  flush (sync, 1 cycle):
//   - all storage, fill_cnt and line_valid cleared next edge;
//   - depth_q <= depth_cfg clamped: 0 -> 1, >MAX_DEPTH -> MAX_DEPTH;
//   - cfg_err=1 for that next cycle if clamping occurred.
//  depth_cfg is ignored except during flush; mid-stream changes have no effect.
//  flush && in_valid same cycle: flush wins, word dropped, not counted.
//  Reset mid-stream: immediate clear, depth_q back to MAX_DEPTH; no residue after release.
//  Arithmetic: fill_cnt and (k+1)*depth_q computed unsigned at CNT_W; no overflow by construction.
// STRUCTURE
//  Shared package cnn_pkg:
//   - typedef logic [DATA_W-1:0] cnn_word_t
//   - default MAX_DEPTH/NUM_LINES localparams
//   - clamp_depth() function
//  Sub-module cnn_shift_line (one MAX_DEPTH-stage shift chain, en, clr, depth_q tap mux).
//   Instantiated NUM_LINES times via generate, chained.
//  Top level holds depth_q, fill_cnt, cfg_err and the line_valid compare.
// TESTING
//  1 Reset: drive rst=0 mid-run -> all outputs 0 same cycle; after release depth_q=MAX_DEPTH.
//  2 flush depth_cfg=4, stream 1,2,3,... every cycle, NUM_LINES=2:
//    -> slice0=1 after 4th shift; line_valid=01 after shift 4, 11 after shift 8; slice1=1 after shift 8.
//  3 Stall: depth 4, in_valid toggling 1010...:
//    -> outputs/line_valid change only on accepted words; delay counted in shifts, not cycles.
//  4 Flush mid-stream with in_valid=1 on same cycle:
//    -> next cycle line_data=0, line_valid=0, dropped word never appears.
//  5 Clamp: flush depth_cfg=0 -> cfg_err pulse, depth 1 (slice0 = previous word).
//    flush depth_cfg=MAX_DEPTH+1 -> cfg_err pulse, depth MAX_DEPTH.
//  6 Mid-stream depth_cfg change without flush -> timing unchanged;
//    takes effect only after next flush.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types, default sizing and helpers for the CNN window line buffer.
package cnn_pkg;

  localparam int unsigned DefDataW    = 48;
  localparam int unsigned DefMaxDepth = 62;
  localparam int unsigned DefNumLines = 2;

  typedef logic [DefDataW-1:0] cnn_word_t;

  // Row length must be in 1..max_depth; out-of-range requests are pulled to the nearest legal value.
  function automatic int unsigned clamp_depth(input int unsigned cfg,
                                              input int unsigned max_depth);
    if (cfg == 0) begin
      return 1;
    end else if (cfg > max_depth) begin
      return max_depth;
    end else begin
      return cfg;
    end
  endfunction

endpackage

// File: rtl/cnn_shift_line.sv
// One row delay: a MAX_DEPTH-stage shift chain with a run-time selectable tap at stage depth-1.
module cnn_shift_line
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_DEPTH = DefMaxDepth,
  parameter int unsigned DEPTH_W   = $clog2(DefMaxDepth + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout
);

  logic [DATA_W-1:0]  stage_q [MAX_DEPTH];
  logic [DEPTH_W-1:0] tap_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MAX_DEPTH); i++) stage_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(MAX_DEPTH); i++) stage_q[i] <= '0;
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(MAX_DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // depth is always 1..MAX_DEPTH here, so the tap index never leaves the array.
  always_comb begin
    tap_idx = depth - DEPTH_W'(1);
    dout    = '0;
    for (int i = 0; i < int'(MAX_DEPTH); i++) begin
      if (DEPTH_W'(i) == tap_idx) dout = stage_q[i];
    end
  end

endmodule

// File: rtl/cnn_line_buffer.sv
// Cascaded multi-row delay buffer feeding the KxK window: per-layer row length, stall and flush.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter  int unsigned DATA_W    = DefDataW,
  parameter  int unsigned MAX_DEPTH = DefMaxDepth,
  parameter  int unsigned NUM_LINES = DefNumLines,
  localparam int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1),
  localparam int unsigned CNT_W     = $clog2(NUM_LINES * MAX_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DEPTH_W-1:0]            depth_cfg,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic [NUM_LINES*DATA_W-1:0]   line_data,
  output logic [NUM_LINES-1:0]          line_valid,
  output logic                          cfg_err
);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d, fill_max;
  logic               cfg_err_q, cfg_err_d;
  logic               shift_en;
  logic [DATA_W-1:0]  chain [NUM_LINES+1];

  assign shift_en = in_valid && !flush;
  assign chain[0] = in_data;

  for (genvar k = 0; k < int'(NUM_LINES); k++) begin : g_line
    cnn_shift_line #(
      .DATA_W    (DATA_W),
      .MAX_DEPTH (MAX_DEPTH),
      .DEPTH_W   (DEPTH_W)
    ) u_line (
      .clk   (clk),
      .rst   (rst),
      .en    (shift_en),
      .clr   (flush),
      .depth (depth_q),
      .din   (chain[k]),
      .dout  (chain[k+1])
    );
    assign line_data[k*DATA_W +: DATA_W] = chain[k+1];
  end

  always_comb begin
    fill_max   = CNT_W'(NUM_LINES) * CNT_W'(depth_q);
    depth_d    = depth_q;
    fill_cnt_d = fill_cnt_q;
    cfg_err_d  = 1'b0;
    if (flush) begin
      depth_d    = DEPTH_W'(clamp_depth(32'(depth_cfg), MAX_DEPTH));
      cfg_err_d  = (depth_cfg == '0) || (32'(depth_cfg) > MAX_DEPTH);
      fill_cnt_d = '0;
    end else if (in_valid && (fill_cnt_q < fill_max)) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_q    <= DEPTH_W'(MAX_DEPTH);
      fill_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      depth_q    <= depth_d;
      fill_cnt_q <= fill_cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Derived from the registered count only, so in_valid never reaches line_valid in the same cycle.
  always_comb begin
    for (int k = 0; k < int'(NUM_LINES); k++) begin
      line_valid[k] = fill_cnt_q >= (CNT_W'(k + 1) * CNT_W'(depth_q));
    end
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_cnn_line_buffer.sv
// Randomised scoreboard bench for cnn_line_buffer against a word-history reference model.
module tb_cnn_line_buffer;
  import cnn_pkg::*;

  localparam int unsigned DATA_W    = 48;
  localparam int unsigned MAX_DEPTH = 62;
  localparam int unsigned NUM_LINES = 2;
  localparam int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1);

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        flush = 1'b0;
  logic [DEPTH_W-1:0]          depth_cfg = '0;
  logic                        in_valid = 1'b0;
  cnn_word_t                   in_data = '0;
  logic [NUM_LINES*DATA_W-1:0] line_data;
  logic [NUM_LINES-1:0]        line_valid;
  logic                        cfg_err;

  typedef struct packed {
    logic [NUM_LINES*DATA_W-1:0] data;
    logic [NUM_LINES-1:0]        valid;
    logic                        err;
  } exp_t;

  exp_t      exp_q[$];
  exp_t      mon_e;
  cnn_word_t hist[$];
  int        m_depth = MAX_DEPTH;
  int        m_cnt   = 0;
  int        checks   = 0;
  int        failures = 0;

  cnn_line_buffer #(
    .DATA_W    (DATA_W),
    .MAX_DEPTH (MAX_DEPTH),
    .NUM_LINES (NUM_LINES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .depth_cfg  (depth_cfg),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .line_data  (line_data),
    .line_valid (line_valid),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: the buffer is a plain history of accepted words; slice k shows the word accepted
  // (k+1)*depth-1 shifts before the newest one, if that many words exist since the last clear.
  task automatic model_step(input logic r, input logic v, input logic fl,
                            input int cfg, input cnn_word_t d);
    exp_t e;
    int   m;
    e = '0;
    if (!r) begin
      hist.delete();
      m_cnt   = 0;
      m_depth = MAX_DEPTH;
    end else if (fl) begin
      hist.delete();
      m_cnt = 0;
      if (cfg == 0) begin
        m_depth = 1;
        e.err   = 1'b1;
      end else if (cfg > int'(MAX_DEPTH)) begin
        m_depth = MAX_DEPTH;
        e.err   = 1'b1;
      end else begin
        m_depth = cfg;
      end
    end else if (v) begin
      hist.push_back(d);
      m_cnt++;
      while (hist.size() > int'(NUM_LINES * MAX_DEPTH)) void'(hist.pop_front());
    end
    for (int k = 0; k < int'(NUM_LINES); k++) begin
      m = (k + 1) * m_depth - 1;
      if (m < hist.size()) e.data[k*DATA_W +: DATA_W] = hist[hist.size() - 1 - m];
      e.valid[k] = (m_cnt >= (k + 1) * m_depth);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input logic fl, input int cfg,
                       input cnn_word_t d);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    flush     = fl;
    depth_cfg = DEPTH_W'(cfg);
    in_data   = d;
    model_step(r, v, fl, cfg, d);
    if (!r) begin
      #1;
      chk("async_rst_data", 128'(line_data), 128'(0));
      chk("async_rst_valid", 128'(line_valid), 128'(0));
      chk("async_rst_err", 128'(cfg_err), 128'(0));
    end
  endtask

  function automatic cnn_word_t rnd_word();
    return DATA_W'({$urandom(), $urandom()});
  endfunction

  // Monitor: outputs are presented every cycle, compared just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("line_data", 128'(line_data), 128'(mon_e.data));
        chk("line_valid", 128'(line_valid), 128'(mon_e.valid));
        chk("cfg_err", 128'(cfg_err), 128'(mon_e.err));
      end
    end
  end

  initial begin
    int len;
    int wait_cyc;
    drive(1'b0, 1'b0, 1'b0, 0, '0);
    drive(1'b0, 1'b0, 1'b0, 0, '0);
    // Default depth after reset is MAX_DEPTH.
    for (int i = 0; i < 130; i++) drive(1'b1, 1'b1, 1'b0, 0, rnd_word());
    // Reset mid-stream with in_valid high, then check nothing survives.
    drive(1'b0, 1'b1, 1'b0, 4, rnd_word());
    drive(1'b0, 1'b1, 1'b0, 4, rnd_word());
    for (int i = 0; i < 130; i++) drive(1'b1, 1'b1, 1'b0, $urandom_range(0, 63), rnd_word());
    // Depth 4, counting stream.
    drive(1'b1, 1'b0, 1'b1, 4, '0);
    for (int i = 1; i <= 12; i++) drive(1'b1, 1'b1, 1'b0, 4, DATA_W'(i));
    // Stall pattern 1010...
    for (int i = 0; i < 40; i++) drive(1'b1, (i % 2) == 0, 1'b0, 4, rnd_word());
    // Flush together with a valid word: the word must be dropped.
    drive(1'b1, 1'b1, 1'b1, 4, 48'hDEAD_BEEF_0001);
    for (int i = 1; i <= 12; i++) drive(1'b1, 1'b1, 1'b0, 4, DATA_W'(100 + i));
    // Clamp low and high.
    drive(1'b1, 1'b0, 1'b1, 0, '0);
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 2) == 0, 1'b0, 0, rnd_word());
    drive(1'b1, 1'b1, 1'b1, int'(MAX_DEPTH) + 1, rnd_word());
    for (int i = 0; i < 130; i++) drive(1'b1, 1'b1, 1'b0, 0, rnd_word());
    // depth_cfg wiggling without flush must not matter.
    drive(1'b1, 1'b0, 1'b1, 5, '0);
    for (int i = 0; i < 30; i++)
      drive(1'b1, $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 63), rnd_word());
    // Random layers.
    for (int ep = 0; ep < 15; ep++) begin
      drive(1'b1, $urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 63), rnd_word());
      len = $urandom_range(10, 140);
      for (int i = 0; i < len; i++)
        drive(1'b1, $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 63), rnd_word());
    end
    drive(1'b1, 1'b0, 1'b0, 0, '0);
    drive(1'b1, 1'b0, 1'b0, 0, '0);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    chk("drain", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
